// File: rtl/adder_tree_pipe.sv
// Pipelined 2^LEVELS-operand adder tree with valid/ready flow control, optional
// two's-complement operands and per-frame accumulation of several beats.
module adder_tree_pipe #(
   parameter int WIDTH    = 11,
   parameter int LEVELS   = 3,
   parameter int SIGNED   = 0,
   parameter int ACC_BITS = 4,
   localparam int N  = 1 << LEVELS,
   localparam int TW = WIDTH + LEVELS,
   localparam int OW = WIDTH + LEVELS + ACC_BITS
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [N*WIDTH-1:0] in_data,
   input  logic               in_acc,
   input  logic               in_last,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [OW-1:0]      out_data,
   output logic               out_ovf
);

   // Tree nodes are stored level by level: leaves first, root last.
   localparam int NODES = 2 * N - 1;
   localparam int ROOT  = 2 * N - 2;

   function automatic int node_off(input int l);
      return 2 * N - ((2 * N) >> l);
   endfunction

   logic [TW-1:0] r_node [NODES];
   logic [TW-1:0] w_leaf [N];
   logic [LEVELS:0] r_vld;
   logic [LEVELS:0] r_acc;
   logic [LEVELS:0] r_last;
   logic [OW-1:0] r_accum;
   logic          r_frame_ovf;
   logic          r_out_valid;
   logic [OW-1:0] r_out_data;
   logic          r_out_ovf;

   logic          w_stall;
   logic [OW-1:0] w_root;
   logic [OW:0]   w_sum_c;
   logic [OW-1:0] w_sum;
   logic          w_ovf;

   assign w_stall   = r_out_valid & ~out_ready;
   assign in_ready  = ~w_stall;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_ovf   = r_out_ovf;

   // Every node is held at the full tree width; the sums are exact at that
   // width, so each level carries the same value as a WIDTH+L wide adder would.
   always_comb begin
      for (int k = 0; k < N; k++) begin
         if (SIGNED != 0)
            w_leaf[k] = TW'($signed(in_data[k*WIDTH +: WIDTH]));
         else
            w_leaf[k] = TW'(in_data[k*WIDTH +: WIDTH]);
      end
   end

   always_comb begin
      if (SIGNED != 0)
         w_root = OW'($signed(r_node[ROOT]));
      else
         w_root = OW'(r_node[ROOT]);
   end

   assign w_sum_c = {1'b0, r_accum} + {1'b0, w_root};
   assign w_sum   = w_sum_c[OW-1:0];
   assign w_ovf   = (SIGNED != 0) ?
                    ((r_accum[OW-1] == w_root[OW-1]) && (w_sum[OW-1] != r_accum[OW-1])) :
                    w_sum_c[OW];

   always_ff @(posedge clk) begin
      if (!w_stall) begin
         for (int k = 0; k < N; k++)
            r_node[k] <= w_leaf[k];
         for (int l = 1; l <= LEVELS; l++)
            for (int k = 0; k < (N >> l); k++)
               r_node[node_off(l) + k] <= r_node[node_off(l-1) + 2*k] +
                                          r_node[node_off(l-1) + 2*k + 1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_vld       <= '0;
         r_acc       <= '0;
         r_last      <= '0;
         r_accum     <= '0;
         r_frame_ovf <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_ovf   <= 1'b0;
      end else if (!w_stall) begin
         r_vld  <= {r_vld[LEVELS-1:0], in_valid};
         r_acc  <= {r_acc[LEVELS-1:0], in_acc};
         r_last <= {r_last[LEVELS-1:0], in_acc & in_last};
         r_out_valid <= 1'b0;
         if (r_vld[LEVELS]) begin
            if (!r_acc[LEVELS]) begin
               r_out_data  <= w_root;
               r_out_ovf   <= 1'b0;
               r_out_valid <= 1'b1;
            end else if (!r_last[LEVELS]) begin
               r_accum     <= w_sum;
               r_frame_ovf <= r_frame_ovf | w_ovf;
            end else begin
               r_out_data  <= w_sum;
               r_out_ovf   <= r_frame_ovf | w_ovf;
               r_out_valid <= 1'b1;
               r_accum     <= '0;
               r_frame_ovf <= 1'b0;
            end
         end
      end
   end

endmodule
